// File: rtl/product_accumulator.sv
// Burst accumulator: sums a length-counted stream of unsigned products into a
// saturating register and hands the result off with a valid/ready handshake.
module product_accumulator #(
    parameter int unsigned PW = 16,
    parameter int unsigned AW = 20,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic          p_valid,
    input  logic [PW-1:0] product,
    output logic          p_ready,
    output logic [AW-1:0] acc_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf,
    output logic          busy
);

    localparam int unsigned SW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum_c;
    logic          accept_c;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Carry out of the widened sum marks a saturating add
    assign accept_c = p_valid && (state_q == ACCUM);
    assign sum_c    = {1'b0, acc_q} + SW'(product);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = len;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c) begin
                    cnt_d = cnt_q - CW'(1);
                    if (ovf_q || sum_c[AW]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_c[AW-1:0];
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode straight from state so reset clears them at once
    assign p_ready   = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a bench-side saturating model
// predicts each burst result, which is compared when the DUT hands it off.
module tb_product_accumulator;

    localparam int unsigned PW = 16;
    localparam int unsigned AW = 20;
    localparam int unsigned CW = 8;
    localparam logic [AW-1:0] ALL_ONES = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          p_valid;
    logic [PW-1:0] product;
    logic          p_ready;
    logic [AW-1:0] acc_out;
    logic          out_valid;
    logic          out_ready;
    logic          ovf;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW:0]   exp_q[$];
    logic [AW-1:0] m_acc;
    logic          m_ovf;

    product_accumulator #(.PW(PW), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .product   (product),
        .p_ready   (p_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Saturating reference model of one add
    task automatic model_add(input logic [PW-1:0] p);
        longint unsigned s;
        s = longint'(m_acc) + longint'(p);
        if (m_ovf || s > longint'(ALL_ONES)) begin
            m_acc = ALL_ONES;
            m_ovf = 1'b1;
        end else begin
            m_acc = AW'(s);
        end
    endtask

    task automatic start_burst(input logic [CW-1:0] l);
        start = 1'b1;
        len   = l;
        m_acc = '0;
        m_ovf = 1'b0;
        if (l == '0) exp_q.push_back({m_ovf, m_acc});
        tick();
        start = 1'b0;
    endtask

    task automatic send_product(input logic [PW-1:0] p, input bit last);
        int waited = 0;
        while (!p_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!p_ready) check("p_ready_timeout", 32'(p_ready), 32'd1);
        p_valid = 1'b1;
        product = p;
        model_add(p);
        if (last) exp_q.push_back({m_ovf, m_acc});
        tick();
        p_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Output monitor: pops the scoreboard on every completed handshake
    always @(negedge clk) begin
        logic [AW:0] e;
        if (!rst) begin
            check("ready_valid_excl", 32'(p_ready & out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_acc", 32'(acc_out), 32'(e[AW-1:0]));
                    check("sb_ovf", 32'(ovf), 32'(e[AW]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; product = '0; out_ready = 1'b1;
        m_acc = '0; m_ovf = 1'b0;
        #2;
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_flags", {28'd0, ovf, out_valid, p_ready, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Basic burst and result latency
        start_burst(8'd3);
        check("basic_busy", 32'(busy), 32'd1);
        send_product(16'd10, 1'b0);
        send_product(16'd20, 1'b0);
        check("basic_no_early_valid", 32'(out_valid), 32'd0);
        send_product(16'd30, 1'b1);
        check("basic_latency", 32'(out_valid), 32'd1);
        check("basic_acc", 32'(acc_out), 32'd60);
        check("basic_ovf", 32'(ovf), 32'd0);
        wait_idle();

        // Gaps and backpressure
        out_ready = 1'b0;
        start_burst(8'd2);
        send_product(16'h0100, 1'b0);
        repeat (3) tick();
        check("gap_hold", 32'(acc_out), 32'h100);
        send_product(16'h0200, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_acc", 32'(acc_out), 32'h00300);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", 32'(out_valid), 32'd0);
        check("idle_retain", 32'(acc_out), 32'h00300);

        // Overflow and sticky saturation
        start_burst(8'd17);
        for (int i = 0; i < 16; i++) send_product(16'hFFFF, 1'b0);
        check("ovf16_acc", 32'(acc_out), 32'h0FFFF0);
        check("ovf16_flag", 32'(ovf), 32'd0);
        send_product(16'hFFFF, 1'b1);
        check("ovf17_acc", 32'(acc_out), 32'h0FFFFF);
        check("ovf17_flag", 32'(ovf), 32'd1);
        wait_idle();
        check("ovf_retain", 32'(ovf), 32'd1);

        // Zero-length burst
        start_burst(8'd0);
        check("zero_valid", 32'(out_valid), 32'd1);
        check("zero_acc", 32'(acc_out), 32'd0);
        check("zero_ovf", 32'(ovf), 32'd0);
        check("zero_no_ready", 32'(p_ready), 32'd0);
        wait_idle();

        // Reset mid-burst discards partial sum
        start_burst(8'd4);
        send_product(16'd7, 1'b0);
        send_product(16'd9, 1'b0);
        check("pre_rst_acc", 32'(acc_out), 32'd16);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_acc", 32'(acc_out), 32'd0);
        check("mid_rst_flags", {28'd0, ovf, out_valid, p_ready, busy}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("mid_rst_stay_idle", 32'(busy), 32'd0);
        start_burst(8'd1);
        send_product(16'd5, 1'b1);
        check("after_rst_acc", 32'(acc_out), 32'd5);
        wait_idle();

        // Start ignored during ACCUM
        start_burst(8'd3);
        send_product(16'd100, 1'b0);
        start = 1'b1;
        len = 8'd9;
        tick();
        start = 1'b0;
        check("ign_start_acc", 32'(acc_out), 32'd100);
        send_product(16'd200, 1'b0);
        send_product(16'd300, 1'b1);
        check("ign_start_done", 32'(out_valid), 32'd1);
        check("ign_start_sum", 32'(acc_out), 32'd600);
        wait_idle();

        // Start together with out_ready in DONE is dropped
        out_ready = 1'b0;
        start_burst(8'd1);
        send_product(16'd42, 1'b1);
        start = 1'b1;
        len = 8'd2;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_idle", 32'(busy), 32'd0);
        tick();
        check("done_start_stay", 32'(busy), 32'd0);
        check("done_start_acc", 32'(acc_out), 32'd42);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PW, default 16, giving the product input width (2*operand width of the multiplier stage).
REQ-002 SHALL have parameter AW, default 20, giving the accumulator width; AW >= PW.
REQ-003 SHALL have parameter CW, default 8, giving the burst length counter width.
REQ-004 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, a request to begin a new accumulation burst.
REQ-007 SHALL have port len, input, CW, the number of products in the burst; sampled only when start is accepted.
REQ-008 SHALL have port p_valid, input, 1, indicating that product holds a valid multiplier result.
REQ-009 SHALL have port product, input, PW, the unsigned product from the upstream multiplier.
REQ-010 SHALL have port p_ready, output, 1, asserted when a product can be accepted.
REQ-011 SHALL have port acc_out, output, AW, the registered burst sum.
REQ-012 SHALL have port out_valid, output, 1, indicating that acc_out holds a completed burst result.
REQ-013 SHALL have port out_ready, input, 1, the downstream acknowledge for the result.
REQ-014 SHALL have port ovf, output, 1, the sticky saturation flag for the current burst.
REQ-015 SHALL have port busy, output, 1, which is high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch len into the remaining count, clear acc_out and ovf, and go to ACCUM.
REQ-018 In IDLE, start=1 with len==0 SHALL clear acc_out and ovf and go directly to DONE, so that out_valid is high on the next cycle with acc_out=0.
REQ-019 start SHALL be ignored in ACCUM and DONE, with no effect on state or data.
REQ-020 p_ready SHALL be 1 only in ACCUM, and SHALL be combinationally derived from the state only.
REQ-021 A product SHALL be accepted only on a cycle where p_valid && p_ready.
REQ-022 Each accepted product SHALL be added to acc_out after zero-extension to AW, and the remaining count SHALL decrement by 1.
REQ-023 A p_valid=0 cycle in ACCUM SHALL leave acc_out and the remaining count unchanged, and may stall the burst indefinitely.
REQ-024 If acc_out + product exceeds 2^AW-1, acc_out SHALL become all-ones and ovf SHALL be set to 1.
REQ-025 Once set, ovf SHALL stay set until the next accepted start; further adds SHALL keep acc_out at all-ones.
REQ-026 Acceptance of the product with remaining count==1 SHALL transition to DONE, so that out_valid rises on the cycle after the last accepted product (latency 1).
REQ-027 In DONE, out_valid SHALL be 1 and acc_out and ovf SHALL be held stable.
REQ-028 In DONE, out_ready=1 SHALL return the FSM to IDLE, and out_valid SHALL drop on the next cycle.
REQ-029 acc_out and ovf SHALL retain their last values in IDLE until the next accepted start.
REQ-030 out_valid SHALL never be asserted outside DONE.
REQ-031 p_ready and out_valid SHALL never be high in the same cycle.
REQ-032 start and out_ready arriving together in DONE SHALL have the following effect: out_ready returns the FSM to IDLE, and start is ignored; a new start is needed in IDLE.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for clk, force IDLE, acc_out=0, ovf=0, out_valid=0, p_ready=0, busy=0 and remaining count=0.
REQ-034 rst asserted mid-burst (ACCUM or DONE) SHALL abort the burst, and the partial sum SHALL be discarded.
REQ-035 After rst deasserts, the block SHALL take no action until start is asserted.

Verification
REQ-036 Bench SHALL cover a basic burst: start, len=3, then products 10, 20, 30 on consecutive cycles -> out_valid one cycle after the third product, acc_out=60, ovf=0.
REQ-037 Bench SHALL cover gaps and backpressure: len=2, products 0x0100 and 0x0200 with 3 idle p_valid=0 cycles between them, and out_ready held low for 5 cycles -> acc_out=0x00300, held stable with out_valid=1 until out_ready rises.
REQ-038 Bench SHALL cover overflow: len=17, all products 0xFFFF -> after 16 products acc_out=0xFFFF0 with ovf=0; after the 17th, acc_out=0xFFFFF with ovf=1.
REQ-039 Bench SHALL cover a zero-length burst: start with len=0 -> next cycle out_valid=1, acc_out=0, and p_ready never asserts.
REQ-040 Bench SHALL cover reset mid-burst: len=4, 2 products accepted, then rst pulsed -> all outputs 0 immediately; a following len=1, product=5 burst gives acc_out=5.
REQ-041 Bench SHALL cover ignored start: start pulsed during ACCUM with len=9 -> the original len burst completes unchanged.
